// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: one full-duplex, MSB-first frame per accepted start.
// Every output is registered and is derived from the next-state values of the frame engine.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  shift_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TRANSFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [DIV_W-1:0]      div_cnt_q,  div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic                  sclk_q,     sclk_d;
    logic                  cs_n_q,     cs_n_d;
    logic                  mosi_q,     mosi_d;
    logic                  shift_en_q, shift_en_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q,     busy_d;
    logic                  div_last;
    logic                  in_frame;

    assign div_last = (div_cnt_q == DIV_LAST);
    assign in_frame = (state_q == S_SETUP) || (state_q == S_TRANSFER) || (state_q == S_HOLD);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        shift_en_d = 1'b0;
        rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_SETUP;
                    tx_shift_d = tx_data;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_d   = S_TRANSFER;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_TRANSFER: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    sclk_d    = !sclk_q;
                    if (!sclk_q) begin
                        // rising edge: capture miso
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                        shift_en_d = 1'b1;
                    end else begin
                        // falling edge: advance mosi to the next bit
                        tx_shift_d = tx_shift_q << 1;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    state_d    = S_DONE;
                    div_cnt_d  = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && in_frame) begin
            state_d    = S_IDLE;
            shift_en_d = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end

        cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
        mosi_d = (state_d == S_IDLE) ? 1'b0 : tx_shift_d[DATA_WIDTH-1];
        if (state_d == S_IDLE) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            shift_en_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            shift_en_q <= shift_en_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
    assign shift_en = shift_en_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default build checked cycle-by-cycle against a timeline model,
// plus a DATA_WIDTH=16 / CLK_DIV=2 build exercised with a directed loopback frame.
module tb_spi_master_ctrl;
    localparam int DW1 = 8;
    localparam int CD1 = 4;
    localparam int T1  = CD1 * (2 * DW1 + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic       start1 = 1'b0, abort1 = 1'b0, loop1 = 1'b1;
    logic [7:0] tx_data1 = '0, slv = '0;
    logic       miso1, sclk1, cs_n1, mosi1, shift_en1, rx_valid1, busy1;
    logic [7:0] rx_data1;

    // wide / fast instance
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [15:0] tx2 = '0;
    logic        miso2, sclk2, cs_n2, mosi2, shift_en2, rx_valid2, busy2;
    logic [15:0] rx_data2;

    int nfall = 0;
    assign miso1 = loop1 ? mosi1 : ((nfall < 8) ? slv[3'(7 - nfall)] : 1'b0);
    assign miso2 = mosi2;

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .tx_data(tx_data1),
        .miso(miso1), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .shift_en(shift_en1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
    );

    spi_master_ctrl #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .tx_data(tx2),
        .miso(miso2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .shift_en(shift_en2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // slave model: one new bit per sclk fall, restarting whenever cs_n is high
    logic prev_sclk1 = 1'b0;
    always @(negedge clk) begin
        if (cs_n1) nfall <= 0;
        else if (prev_sclk1 && !sclk1) nfall <= nfall + 1;
        prev_sclk1 <= sclk1;
    end

    // timeline model: a frame is just "cycles since acceptance"
    logic       m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_tx = '0, m_frx = '0, m_rxd = '0;
    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            m_t   = 0;
            m_rxd = '0;
        end else if (m_act) begin
            if (m_t == T1) m_act = 1'b0;
            else if (abort1) m_act = 1'b0;
            else m_t = m_t + 1;
            if (m_act && m_t == T1) m_rxd = m_frx;
        end else if (start1 && !abort1) begin
            m_act = 1'b1;
            m_t   = 0;
            m_tx  = tx_data1;
            m_frx = loop1 ? tx_data1 : slv;
        end
    end

    logic e_cs, e_sclk, e_mosi, e_shen, e_rxv, e_busy, mchk;
    int   mp, mj;
    always @(negedge clk) begin
        if (cmp_en) begin
            if (!m_act) begin
                e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_shen = 1'b0;
                e_rxv = 1'b0; e_busy = 1'b0; mchk = 1'b1;
            end else begin
                mp     = m_t / CD1;
                e_busy = 1'b1;
                e_cs   = (m_t == T1);
                e_rxv  = (m_t == T1);
                e_sclk = (mp >= 2) && (mp <= 2 * DW1) && (mp % 2 == 0);
                e_shen = e_sclk && (m_t % CD1 == 0);
                mj     = (mp <= 2) ? 0 : (mp - 1) / 2;
                mchk   = (mj < DW1);
                e_mosi = mchk ? m_tx[3'(DW1 - 1 - mj)] : 1'b0;
            end
            chk("m_cs_n", cs_n1, e_cs);
            chk("m_sclk", sclk1, e_sclk);
            chk("m_shift_en", shift_en1, e_shen);
            chk("m_rx_valid", rx_valid1, e_rxv);
            chk("m_busy", busy1, e_busy);
            chk("m_rx_data", rx_data1, m_rxd);
            if (mchk) chk("m_mosi", mosi1, e_mosi);
        end
    end

    // observation mux so one frame-measuring task serves both builds
    logic        sel = 1'b0;
    wire         o_sclk = sel ? sclk2 : sclk1;
    wire         o_mosi = sel ? mosi2 : mosi1;
    wire         o_shen = sel ? shift_en2 : shift_en1;
    wire         o_rxv  = sel ? rx_valid2 : rx_valid1;
    wire         o_cs_n = sel ? cs_n2 : cs_n1;
    wire [15:0]  o_rxd  = sel ? rx_data2 : {8'h00, rx_data1};

    task automatic frame_run(input logic s, input logic [15:0] tx, input logic lp,
                             input logic [7:0] sw, input int hp,
                             output int lat, output logic [15:0] rxd, output int nsh,
                             output logic [15:0] mbits, output int frise,
                             output logic hp_ok, output logic csv);
        int e0, t, last_tog;
        logic prev;
        sel = s;
        @(negedge clk);
        if (s) begin
            tx2 = tx; start2 = 1'b1;
        end else begin
            tx_data1 = tx[7:0]; loop1 = lp; slv = sw; start1 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        e0 = cyc; lat = -1; rxd = '0; nsh = 0; mbits = '0; frise = -1;
        hp_ok = 1'b1; csv = 1'b0; last_tog = -1; prev = 1'b0;
        for (int k = 0; k < 300; k++) begin
            t = cyc - e0;
            if (o_shen) nsh++;
            if (o_sclk != prev) begin
                if (o_sclk && frise < 0) frise = t;
                if (o_sclk) mbits = {mbits[14:0], o_mosi};
                if (last_tog >= 0 && (t - last_tog) != hp) hp_ok = 1'b0;
                last_tog = t;
            end
            prev = o_sclk;
            if (o_rxv) begin
                lat = t; rxd = o_rxd; csv = o_cs_n;
                break;
            end
            @(negedge clk);
        end
    endtask

    int          lat, nsh, frise, e0, v1, f2, sh, n3;
    logic [15:0] rxd, mbits;
    logic        hp_ok, csv, seen;
    logic [7:0]  r1, r2;

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;

        // quiet idle after reset
        sh = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (shift_en1) sh++;
        end
        chk("idle_shift_en_count", sh, 0);
        chk("idle_cs_n", cs_n1, 1'b1);
        chk("idle_sclk", sclk1, 1'b0);
        chk("idle_busy", busy1, 1'b0);
        chk("idle_rx_valid", rx_valid1, 1'b0);

        // loopback 0xA5
        frame_run(1'b0, 16'h00A5, 1'b1, 8'h00, CD1, lat, rxd, nsh, mbits, frise, hp_ok, csv);
        chk("a5_latency", lat, 72);
        chk("a5_rx_data", rxd, 16'h00A5);
        chk("a5_shift_en_count", nsh, 8);
        chk("a5_mosi_bits", mbits, 16'h00A5);
        chk("a5_cs_n_at_valid", csv, 1'b1);

        // slave returns 0xC3 while master sends 0x3C
        frame_run(1'b0, 16'h003C, 1'b0, 8'hC3, CD1, lat, rxd, nsh, mbits, frise, hp_ok, csv);
        chk("c3_rx_data", rxd, 16'h00C3);
        chk("c3_first_rise", frise, 8);
        chk("c3_half_period", hp_ok, 1'b1);
        chk("c3_mosi_bits", mbits, 16'h003C);
        chk("c3_latency", lat, 72);
        loop1 = 1'b1;

        // start held high, tx_data changed mid-frame
        @(negedge clk);
        tx_data1 = 8'h96; start1 = 1'b1;
        @(negedge clk);
        e0 = cyc; v1 = -1; r1 = '0;
        for (int k = 0; k < 200; k++) begin
            if (cyc - e0 == 20) tx_data1 = 8'h0F;
            if (rx_valid1) begin v1 = cyc; r1 = rx_data1; break; end
            @(negedge clk);
        end
        chk("held_rx1", r1, 8'h96);
        chk("held_latency", v1 - e0, 72);
        f2 = -1000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!cs_n1) begin f2 = cyc; break; end
        end
        start1 = 1'b0;
        chk("held_gap_at_least_2", ((f2 - v1) >= 2) ? 1 : 0, 1);
        r2 = '0;
        for (int k = 0; k < 200; k++) begin
            if (rx_valid1) begin r2 = rx_data1; break; end
            @(negedge clk);
        end
        chk("held_rx2", r2, 8'h0F);
        repeat (5) @(negedge clk);

        // abort together with start in IDLE: nothing starts
        tx_data1 = 8'hFF; start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        chk("abort_start_cs_n", cs_n1, 1'b1);
        chk("abort_start_busy", busy1, 1'b0);

        // abort after the third shift_en
        @(negedge clk);
        tx_data1 = 8'h77; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n3 = 0;
        for (int k = 0; k < 200; k++) begin
            if (shift_en1) n3++;
            if (n3 == 3) break;
            @(negedge clk);
        end
        chk("abort_reached_3rd", n3, 3);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_cs_n", cs_n1, 1'b1);
        chk("abort_sclk", sclk1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_valid1) seen = 1'b1;
        end
        chk("abort_no_rx_valid", seen, 1'b0);
        chk("abort_rx_kept", rx_data1, 8'h0F);
        frame_run(1'b0, 16'h005A, 1'b1, 8'h00, CD1, lat, rxd, nsh, mbits, frise, hp_ok, csv);
        chk("post_abort_latency", lat, 72);
        chk("post_abort_rx", rxd, 16'h005A);

        // reset in mid-TRANSFER on both builds
        @(negedge clk);
        tx_data1 = 8'hE1; start1 = 1'b1; tx2 = 16'h1234; start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cs_n", {cs_n2, cs_n1}, 2'b11);
        chk("rst_sclk", {sclk2, sclk1}, 2'b00);
        chk("rst_mosi", {mosi2, mosi1}, 2'b00);
        chk("rst_shift_en", {shift_en2, shift_en1}, 2'b00);
        chk("rst_rx_valid", {rx_valid2, rx_valid1}, 2'b00);
        chk("rst_busy", {busy2, busy1}, 2'b00);
        chk("rst_rx_data1", rx_data1, 8'h00);
        chk("rst_rx_data2", rx_data2, 16'h0000);

        // 16-bit, CLK_DIV=2 loopback
        frame_run(1'b1, 16'h8001, 1'b1, 8'h00, 2, lat, rxd, nsh, mbits, frise, hp_ok, csv);
        chk("w16_latency", lat, 68);
        chk("w16_rx_data", rxd, 16'h8001);
        chk("w16_shift_en_count", nsh, 16);
        chk("w16_mosi_bits", mbits, 16'h8001);
        chk("w16_first_rise", frise, 4);
        chk("w16_half_period", hp_ok, 1'b1);
        sel = 1'b0;

        // randomized traffic on the default build
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!m_act) begin
                loop1 = 1'($urandom % 2);
                slv   = 8'($urandom);
            end
            tx_data1 = 8'($urandom);
            start1   = ($urandom % 6 == 0);
            abort1   = ($urandom % 300 == 0);
        end
        start1 = 1'b0; abort1 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!m_act && cs_n1) begin seen = 1'b1; break; end
        end
        chk("drain_idle", seen, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master sequencer, mode 0 (CPOL=0, CPHA=0), for one full-duplex frame of DATA_WIDTH bits, MSB first.
- Generates cs_n, sclk and mosi.
- Pulses shift_en once per sampling edge so an external receive shift register can capture miso.
- Also assembles the frame internally and presents it on rx_data with a one-cycle rx_valid strobe.
- Sits between the host-side register interface and the SPI pins.

Parameters:
DATA_WIDTH, 8, bits per frame (≥2)
CLK_DIV, 4, system clocks per sclk half-period (≥2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request a frame; sampled only in IDLE
abort  input  1  cancel the current frame; priority over all but rst
tx_data  input  DATA_WIDTH  frame to send; latched when start is accepted
miso  input  1  serial data from slave
sclk  output  1  SPI clock, idle low
cs_n  output  1  chip select, active low
mosi  output  1  serial data to slave
shift_en  output  1  one-cycle strobe per sampling edge, for the external shift-in register
rx_data  output  DATA_WIDTH  last completed received frame
rx_valid  output  1  one-cycle pulse; rx_data updated
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge), all outputs registered:
  - state=IDLE, cs_n=1, sclk=0, mosi=0, shift_en=0, rx_data=0, rx_valid=0, busy=0.
  - All counters cleared.
  - Applies in any state, including mid-frame.
- States: IDLE, SETUP, TRANSFER, HOLD, DONE.
- IDLE:
  - start=1 at edge E0: latch tx_data into tx_shift, clear bit_cnt and div_cnt, then go to SETUP.
  - From E0: cs_n=0, mosi=tx_data[MSB], busy=1.
- SETUP:
  - cs_n low, sclk low, for CLK_DIV cycles (chip-select setup time), then go to TRANSFER.
- TRANSFER:
  - div_cnt counts 0..CLK_DIV-1. At the terminal count, sclk toggles and div_cnt wraps to 0.
  - Rising toggle (0→1), at the same edge:
    - sample miso into rx_shift (shift left, LSB in);
    - assert shift_en for exactly that one cycle.
  - Falling toggle (1→0):
    - shift tx_shift left, so mosi presents the next bit;
    - bit_cnt increments.
  - After the DATA_WIDTH-th falling toggle, go to HOLD.
  - mosi changes only at falling toggles, or at E0 for the MSB.
  - Exactly DATA_WIDTH shift_en pulses and DATA_WIDTH sclk periods per frame.
- HOLD:
  - cs_n low, sclk low, for CLK_DIV cycles (chip-select hold time), then go to DONE.
- DONE (one cycle):
  - cs_n=1, rx_data←rx_shift, rx_valid=1, busy=1.
  - Next state is IDLE.
- Latency: rx_valid is high in the cycle starting CLK_DIV·(2·DATA_WIDTH+2) clocks after E0. With defaults, that is 72 clocks.
- start handling:
  - start is ignored outside IDLE, and is not queued.
  - A new start is accepted no earlier than the first IDLE cycle after DONE.
  - Minimum frame-to-frame spacing is CLK_DIV·(2·DATA_WIDTH+2)+2 clocks.
- abort=1 in SETUP, TRANSFER or HOLD: at the next edge go to IDLE with cs_n=1, sclk=0, shift_en=0.
  - rx_valid is not asserted and rx_data keeps its previous value.
- abort in IDLE or DONE has no effect; DONE completes normally.
- abort and start together in IDLE: abort wins and the frame is not started.
- tx_data changes after acceptance do not affect the frame in progress.
- mosi returns to 0 in IDLE.

Test Plan:
- Reset, then idle 20 clocks → cs_n=1, sclk=0, busy=0, rx_valid=0, shift_en never asserted.
- Defaults, tx_data=0xA5 with slave looping mosi→miso → mosi bit sequence 1,0,1,0,0,1,0,1 sampled on sclk rises; exactly 8 shift_en pulses; rx_valid at E0+72 with rx_data=0xA5; cs_n high again at the rx_valid cycle.
- tx_data=0x3C with miso driven from a slave model returning 0xC3 → rx_data=0xC3; each sclk half-period measures 4 clocks; first sclk rise 8 clocks after E0.
- start held high continuously, with tx_data changed mid-frame → one frame per accept; second cs_n fall no earlier than 2 clocks after the first rx_valid; first frame carries the original tx_data.
- abort after the 3rd shift_en → cs_n=1 and sclk=0 next clock; no rx_valid; rx_data keeps the prior value; a following start runs a clean full frame.
- rst asserted in mid-TRANSFER, then CLK_DIV=2, DATA_WIDTH=16 build with tx_data=0x8001 → clean reset values; the new frame gives rx_valid at E0+68 with looped rx_data=0x8001.
